// File: rtl/io_burst_writer_if.sv
// rtl/io_burst_writer_if.sv - device byte stream feeding the IO burst writer FIFO
interface io_burst_writer_if #(
    parameter int WSZ = 8
);
    logic           dev_valid;
    logic [WSZ-1:0] dev_data;
    logic           dev_ready;

    modport master (output dev_valid, output dev_data, input dev_ready);
    modport slave  (input dev_valid, input dev_data, output dev_ready);
endinterface

// File: rtl/io_burst_writer.sv
// rtl/io_burst_writer.sv - device FIFO to DMA IO port burst writer with rx config writes
// Optional dropped-beat counter enabled by defining IO_BURST_STATS_EN.
module io_burst_writer #(
    parameter int SZ         = 8,
    parameter int WSZ        = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic             io_clk,
    input  logic             rst,
    io_burst_writer_if.slave dev,
    input  logic             io_rx_interrupt,
    inout  wire  [SZ-1:0]    io_addr,
    inout  wire  [WSZ-1:0]   io_data,
    output logic             io_w_notr,
    output logic             io_tx_interrupt,
    output logic             burst_done,
    output logic [7:0]       drop_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]     r_state;
    logic [WSZ-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]  r_head;
    logic [AW-1:0]  r_tail;
    logic [AW-1:0]  r_h0;
    logic [CW-1:0]  r_count;
    logic [SZ-1:0]  r_base;
    logic [SZ-1:0]  r_b;
    logic [2:0]     r_len;
    logic [2:0]     r_n;
    logic [2:0]     r_k;
    logic [2:0]     r_pk;
    logic           r_enable;
    logic           r_armed;
    logic           r_pv;

    logic           w_intent;
    logic           w_push;
    logic           w_pop;
    logic           w_drop;
    logic           w_start;
    logic           w_cfg_base;
    logic           w_cfg_len;
    logic           w_cfg_ctl;
    logic           w_flush;
    logic [2:0]     w_len_new;

    // r_k is the next beat to present; the DMA owning the bus masks it combinationally
    assign w_intent        = (r_state == S_WRITE) && (r_k < r_n);
    assign io_w_notr       = w_intent && !io_rx_interrupt;
    assign io_tx_interrupt = io_w_notr && (r_k == r_n - 3'd1);
    assign io_addr         = io_w_notr ? r_b + SZ'(r_k) : {SZ{1'bz}};
    assign io_data         = io_w_notr ? r_mem[r_h0 + AW'(r_k)] : {WSZ{1'bz}};
    assign burst_done      = (r_state == S_DONE);

    // a beat presented last cycle survives only if the DMA stays off the bus this cycle
    assign w_pop  = r_pv && !io_rx_interrupt;
    assign w_drop = r_pv && io_rx_interrupt;

    assign dev.dev_ready = (r_count < CW'(FIFO_DEPTH));
    assign w_push        = dev.dev_valid && dev.dev_ready;

    assign w_cfg_base = io_rx_interrupt && (io_addr == SZ'(0));
    assign w_cfg_len  = io_rx_interrupt && (io_addr == SZ'(1));
    assign w_cfg_ctl  = io_rx_interrupt && (io_addr == SZ'(2));
    assign w_flush    = w_cfg_ctl && io_data[2] && (r_state == S_IDLE);
    assign w_len_new  = (io_data[2:0] == 3'd0 || io_data[2:0] > 3'd4) ? 3'd4 : io_data[2:0];
    assign w_start    = (r_state == S_IDLE) && r_enable && r_armed && (r_count >= CW'(r_len));

    always_ff @(posedge io_clk) begin
        if (w_push) r_mem[r_tail] <= dev.dev_data;
    end

    always_ff @(posedge io_clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_head   <= '0;
            r_tail   <= '0;
            r_h0     <= '0;
            r_count  <= '0;
            r_base   <= '0;
            r_b      <= '0;
            r_len    <= 3'd4;
            r_n      <= 3'd4;
            r_k      <= '0;
            r_pk     <= '0;
            r_enable <= 1'b0;
            r_armed  <= 1'b1;
            r_pv     <= 1'b0;
        end else begin
            if (w_flush) begin
                r_head  <= r_tail;
                r_count <= '0;
            end else begin
                if (w_push) r_tail <= r_tail + AW'(1);
                if (w_pop)  r_head <= r_head + AW'(1);
                if (w_push && !w_pop)      r_count <= r_count + CW'(1);
                else if (w_pop && !w_push) r_count <= r_count - CW'(1);
            end

            r_pv <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state <= S_WRITE;
                        r_b     <= r_base;
                        r_n     <= r_len;
                        r_h0    <= r_head;
                        r_k     <= '0;
                    end
                end
                S_WRITE: begin
                    if (w_drop) begin
                        r_k <= r_pk;
                    end else if (io_w_notr) begin
                        r_k  <= r_k + 3'd1;
                        r_pk <= r_k;
                        r_pv <= 1'b1;
                    end
                    if (w_pop && r_pk == r_n - 3'd1) r_state <= S_DONE;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_base  <= r_b + SZ'(r_n);
                    r_armed <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase

            // explicit config writes land after the burst bookkeeping so they win
            if (w_cfg_base) r_base <= SZ'(io_data);
            if (w_cfg_len)  r_len  <= w_len_new;
            if (w_cfg_ctl) begin
                r_enable <= io_data[0];
                if (io_data[1]) r_armed <= 1'b1;
            end
        end
    end

`ifdef IO_BURST_STATS_EN
    logic [7:0] r_drop_cnt;

    always_ff @(posedge io_clk or negedge rst) begin
        if (!rst)                            r_drop_cnt <= '0;
        else if (w_drop && r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
    end

    assign drop_count = r_drop_cnt;
`else
    assign drop_count = 8'd0;
`endif

endmodule

// File: tb/tb_io_burst_writer.sv
// tb/tb_io_burst_writer.sv - randomized scoreboard bench for io_burst_writer
`timescale 1ns/1ps
module tb_io_burst_writer;
    logic       io_clk = 1'b0;
    logic       rst;
    logic       tb_rx;
    logic [7:0] tb_addr;
    logic [7:0] tb_data;
    wire  [7:0] io_addr;
    wire  [7:0] io_data;
    logic       io_w_notr;
    logic       io_tx_interrupt;
    logic       burst_done;
    logic [7:0] drop_count;

    always #5 io_clk = ~io_clk;

    io_burst_writer_if #(.WSZ(8)) dev_if ();

    assign io_addr = tb_rx ? tb_addr : 8'hzz;
    assign io_data = tb_rx ? tb_data : 8'hzz;

    io_burst_writer #(.SZ(8), .WSZ(8), .FIFO_DEPTH(8)) dut (
        .io_clk          (io_clk),
        .rst             (rst),
        .dev             (dev_if),
        .io_rx_interrupt (tb_rx),
        .io_addr         (io_addr),
        .io_data         (io_data),
        .io_w_notr       (io_w_notr),
        .io_tx_interrupt (io_tx_interrupt),
        .burst_done      (burst_done),
        .drop_count      (drop_count)
    );

    int n_total = 0;
    int n_pass  = 0;

    // reference model state
    logic [7:0] m_base;
    int         m_len;
    bit         m_enable;
    bit         m_armed;
    logic [7:0] m_fifo [$];
    logic [31:0] exp_q [$];
    int exp_done  = 0;
    int done_seen = 0;
    int present_cnt = 0;
    int exp_drops = 0;
    int cyc = 0;
    int last_tx_cyc = -100;
    bit pend = 0;
    logic [31:0] pend_beat;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    endtask

    function automatic int exp_drop_val();
`ifdef IO_BURST_STATS_EN
        return (exp_drops > 255) ? 255 : exp_drops;
`else
        return 0;
`endif
    endfunction

    task automatic model_reset();
        m_base = 8'h00; m_len = 4; m_enable = 0; m_armed = 1;
        m_fifo.delete(); exp_q.delete();
        exp_drops = 0; exp_done = done_seen;
    endtask

    task automatic model_try_start();
        logic [7:0] a;
        if (m_enable && m_armed && m_fifo.size() >= m_len) begin
            for (int i = 0; i < m_len; i++) begin
                a = m_base + 8'(i);
                exp_q.push_back({15'd0, (i == m_len - 1), a, m_fifo.pop_front()});
            end
            m_base  = m_base + 8'(m_len);
            m_armed = 0;
            exp_done++;
        end
    endtask

    task automatic cfg(input logic [7:0] a, input logic [7:0] d);
        tb_rx = 1; tb_addr = a; tb_data = d;
        @(posedge io_clk); #1;
        tb_rx = 0;
        case (a)
            8'h00: m_base = d;
            8'h01: m_len = (d[2:0] == 3'd0 || d[2:0] > 3'd4) ? 4 : int'(d[2:0]);
            8'h02: begin
                m_enable = d[0];
                if (d[1]) m_armed = 1;
                if (d[2]) m_fifo.delete();
            end
            default: ;
        endcase
        model_try_start();
    endtask

    task automatic push(input logic [7:0] b);
        int t;
        t = 0;
        while (!dev_if.dev_ready && t < 100) begin @(posedge io_clk); #1; t++; end
        if (!dev_if.dev_ready) begin
            check("push_ready_timeout", 32'(dev_if.dev_ready), 32'd1);
        end else begin
            dev_if.dev_valid = 1; dev_if.dev_data = b;
            @(posedge io_clk); #1;
            dev_if.dev_valid = 0;
            m_fifo.push_back(b);
            model_try_start();
        end
    endtask

    task automatic wait_done(input int budget, input bit inject, input bit collide);
        int base_cnt;
        bit collided;
        base_cnt = present_cnt;
        collided = 0;
        for (int c = 0; c < budget && done_seen < exp_done; c++) begin
            tb_rx = 0;
            if (collide && !collided && present_cnt == base_cnt + 2) begin
                tb_rx = 1; tb_addr = 8'hC5; tb_data = 8'($urandom); collided = 1;
            end else if (inject && $urandom_range(0, 3) == 0) begin
                tb_rx = 1; tb_addr = 8'h80 | 8'($urandom_range(0, 127)); tb_data = 8'($urandom);
            end
            @(posedge io_clk); #1;
        end
        tb_rx = 0;
        check("burst_done_count", 32'(done_seen), 32'(exp_done));
        check("all_beats_confirmed", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic monitor();
        logic [31:0] req;
        forever begin
            @(negedge io_clk);
            cyc++;
            if (!rst) begin
                pend = 0;
            end else begin
                if (tb_rx) check("no_drive_during_rx", 32'(io_w_notr), 32'd0);
                if (pend) begin
                    if (tb_rx) exp_drops++;
                    else begin
                        req = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
                        check("beat_tx_addr_data", pend_beat, req);
                    end
                end
                pend = io_w_notr;
                pend_beat = {15'd0, io_tx_interrupt, io_addr, io_data};
                if (io_w_notr) present_cnt++;
                if (io_w_notr && io_tx_interrupt) last_tx_cyc = cyc;
                if (burst_done) begin
                    done_seen++;
                    check("done_latency", 32'(cyc - last_tx_cyc), 32'd2);
                end
            end
        end
    endtask

    initial begin
        int base_cnt;
        int need;
        int total;
        int t;
        rst = 0; tb_rx = 0; tb_addr = 0; tb_data = 0;
        dev_if.dev_valid = 0; dev_if.dev_data = 0;
        model_reset();
        fork
            monitor();
            begin
                repeat (3) @(posedge io_clk);
                #1 rst = 1;
                check("reset_dev_ready", 32'(dev_if.dev_ready), 32'd1);
                check("reset_w_notr", 32'(io_w_notr), 32'd0);
                check("reset_tx", 32'(io_tx_interrupt), 32'd0);
                check("reset_burst_done", 32'(burst_done), 32'd0);
                check("reset_drop_count", 32'(drop_count), 32'd0);

                // basic three-beat burst
                cfg(8'h00, 8'h10); cfg(8'h01, 8'h03); cfg(8'h02, 8'h01);
                push(8'hA1); push(8'hA2); push(8'hA3);
                wait_done(50, 0, 0);

                // disarmed until rearm, then continues from base 0x13
                base_cnt = present_cnt;
                push(8'hB1); push(8'hB2); push(8'hB3);
                repeat (20) @(posedge io_clk); #1;
                check("no_beats_while_disarmed", 32'(present_cnt - base_cnt), 32'd0);
                cfg(8'h02, 8'h03);
                wait_done(50, 0, 0);

                // len 0 stored as 4, address wraps
                cfg(8'h00, 8'hFE); cfg(8'h01, 8'h00); cfg(8'h02, 8'h03);
                for (int i = 0; i < 4; i++) push(8'($urandom));
                wait_done(50, 0, 0);

                // rx collision right after beat 1
                cfg(8'h00, 8'($urandom)); cfg(8'h01, 8'h04); cfg(8'h02, 8'h03);
                for (int i = 0; i < 4; i++) push(8'($urandom));
                wait_done(50, 0, 1);
                check("drop_after_collision", 32'(drop_count), 32'(exp_drop_val()));

                // FIFO fills at 8 with enable off, then flush
                cfg(8'h02, 8'h00);
                for (int i = 0; i < 8; i++) push(8'($urandom));
                check("full_dev_ready", 32'(dev_if.dev_ready), 32'd0);
                dev_if.dev_valid = 1; dev_if.dev_data = 8'h99;
                for (int i = 0; i < 3; i++) begin
                    @(posedge io_clk); #1;
                    check("ninth_held_off", 32'(dev_if.dev_ready), 32'd0);
                end
                dev_if.dev_valid = 0;
                cfg(8'h02, 8'h04);
                check("flush_dev_ready", 32'(dev_if.dev_ready), 32'd1);

                // randomized bursts with random DMA bus claims
                for (int it = 0; it < 20; it++) begin
                    cfg(8'h00, 8'($urandom));
                    cfg(8'h01, 8'($urandom));
                    need  = (m_len > m_fifo.size()) ? m_len - m_fifo.size() : 0;
                    total = need + $urandom_range(0, 1);
                    if (m_fifo.size() + total > 8) total = 8 - m_fifo.size();
                    for (int i = 0; i < total; i++) push(8'($urandom));
                    cfg(8'h02, 8'h03);
                    wait_done(300, 1, 0);
                end
                check("drop_count_random", 32'(drop_count), 32'(exp_drop_val()));

                // reset during beat 2
                cfg(8'h00, 8'($urandom)); cfg(8'h01, 8'h04);
                for (int i = 0; i < 4; i++) push(8'($urandom));
                base_cnt = present_cnt;
                cfg(8'h02, 8'h03);
                t = 0;
                while (present_cnt != base_cnt + 2 && t < 50) begin @(posedge io_clk); #1; t++; end
                check("reached_beat2", 32'(present_cnt - base_cnt), 32'd2);
                #2 rst = 0;
                #1;
                check("rst_w_notr_immediate", 32'(io_w_notr), 32'd0);
                check("rst_tx_immediate", 32'(io_tx_interrupt), 32'd0);
                model_reset();
                repeat (2) @(posedge io_clk);
                #1 rst = 1;
                check("post_rst_dev_ready", 32'(dev_if.dev_ready), 32'd1);
                check("post_rst_burst_done", 32'(burst_done), 32'd0);
                check("post_rst_drop_count", 32'(drop_count), 32'd0);

                // FIFO empty and len 4 after reset: 3 bytes must not start a burst
                cfg(8'h02, 8'h01);
                base_cnt = present_cnt;
                for (int i = 0; i < 3; i++) push(8'($urandom));
                repeat (15) @(posedge io_clk); #1;
                check("post_rst_no_early_burst", 32'(present_cnt - base_cnt), 32'd0);
                push(8'($urandom));
                wait_done(50, 0, 0);
                check("final_drop_count", 32'(drop_count), 32'(exp_drop_val()));
            end
            begin
                repeat (50000) @(posedge io_clk);
                n_total++;
                $display("FAIL watchdog: bench still running after 50000 cycles, want completion");
            end
        join_any
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/io_burst_writer.md
Name: io_burst_writer

Overview:
- IO-side producer feeding the DMA IO port, clocked by io_clk.
- Collects bytes from a device stream into a local FIFO and emits write bursts of 1..4 beats on the shared io_addr/io_data bus, flagging the last beat with io_tx_interrupt.
- Receives DMA-to-IO messages (io_rx_interrupt cycles) and uses them as configuration writes.
- Burst length is capped at 4 because the DMA IO buffer holds 4 entries.

Parameters:
- SZ, 8, address width.
- WSZ, 8, data width.
- FIFO_DEPTH, 8, device FIFO entries; power of two, at least 4.

Ports:
- io_clk  input  1  clock.
- rst  input  1  asynchronous, active-low reset.
- dev_valid  input  1  device byte valid.
- dev_data  input  WSZ  device byte.
- dev_ready  output  1  FIFO can accept a byte.
- io_rx_interrupt  input  1  DMA drives the bus this cycle.
- io_addr  inout  SZ  shared address bus.
- io_data  inout  WSZ  shared data bus.
- io_w_notr  output  1  write beat present.
- io_tx_interrupt  output  1  last beat of the burst.
- burst_done  output  1  one-cycle pulse when a burst has been confirmed.
- drop_count  output  8  dropped-beat counter (see Optional Feature).

Behaviour:
- Reset: rst is asynchronous, active-low; clock io_clk. Reset values:
  - dev_ready=1; io_w_notr=0; io_tx_interrupt=0; burst_done=0; drop_count=0.
  - FIFO empty; base=0; len=4; enable=0; armed=1; state IDLE.
  - Bus released immediately on reset assertion, including mid-burst. Queued data is discarded.
- Bus drive: io_addr/io_data are driven only while io_w_notr=1; otherwise high-Z.
  - io_w_notr and io_tx_interrupt = registered intent AND NOT io_rx_interrupt. This gating is combinational so the block never contends with the DMA.
- Config writes: at each posedge with io_rx_interrupt=1, sample io_addr/io_data.
  - 0x00: base <= data.
  - 0x01: len <= data[2:0]. Values 0 or >4 are stored as 4.
  - 0x02: enable <= bit0; armed <= 1 if bit1 set; FIFO flushed if bit2 set (ignored unless IDLE).
  - Other addresses are ignored.
  - Config writes take effect for the next burst. base and len are latched at burst start.
- FIFO:
  - dev_ready = (count < FIFO_DEPTH).
  - Push on dev_valid & dev_ready.
  - Pop on beat confirmation.
  - Simultaneous push and pop is allowed; count is unchanged.
- FSM IDLE -> WRITE -> DONE -> IDLE:
  - IDLE: start when enable & armed & count >= len. Latch b=base and n=len, set k=0, then go to WRITE.
  - WRITE: present beat k each cycle.
    - Address = (b+k) mod 2^SZ.
    - Data = FIFO entry at offset k from the head.
    - io_tx_interrupt set on k=n-1.
  - DONE: lasts one cycle, then IDLE.
    - burst_done=1; base <= (b+n) mod 2^SZ; armed <= 0.
    - No further bursts until a rearm command (0x02 bit1).
- Confirmation pipeline: the DMA may claim the bus on the edge that ends a beat cycle, and that beat is then lost.
  - A beat presented in cycle N is confirmed only if io_rx_interrupt=0 throughout cycle N+1.
  - If io_rx_interrupt=1 in cycle N+1, beat N is dropped: k rewinds to that beat, drop_count increments, and the beat is reissued, including io_tx_interrupt if it was the last beat.
  - Cycles in which io_rx_interrupt=1 issue no beat.
  - The FIFO head advances only on confirmation.
- Timing: with no rx activity, n beats occupy n consecutive cycles. burst_done fires 2 cycles after the last beat is presented.
- enable cleared mid-burst: the burst completes. Only the start condition checks enable.

Optional Feature:
- Macro: IO_BURST_STATS_EN.
- Defined: drop_count is an 8-bit counter, saturating at 255, cleared only by reset.
- Not defined: drop_count is tied to 0 and no counter logic exists.

Test Plan:
- Basic burst: rx config base=0x10, len=3, enable=1; push 0xA1, 0xA2, 0xA3.
  - Required: beats (0x10,0xA1), (0x11,0xA2), (0x12,0xA3) on 3 consecutive cycles; tx only on the third.
  - Then burst_done, base=0x13, FIFO empty.
- Default length and wrap: base=0xFE, len=0 (stored as 4), 4 bytes pushed.
  - Required: addresses 0xFE, 0xFF, 0x00, 0x01.
- Rx collision: assert io_rx_interrupt in the cycle after beat k=1 of a 4-beat burst.
  - Required: no bus drive while rx is high; beat 1 reissued with the same addr/data; drop_count=1 (macro on) or 0 (macro off); 4 confirmed beats total.
- Arming: after a completed burst, push 4 more bytes.
  - Required: no beats until a rx write to 0x02 with value 0x03, after which the burst starts.
- FIFO full: push 9 bytes with enable=0.
  - Required: dev_ready=0 after 8 bytes; the 9th byte is held off by dev_ready.
- Reset mid-burst: pull rst low during beat 2.
  - Required: io_w_notr=0 and bus high-Z immediately; after release, all registers at reset values and FIFO empty.
